// File: rtl/exe_stage_if.sv
// Hand-off bundle around the execute stage: ID->EXE instruction fields and
// the EXE->MEM result, each with its own valid/allowin pair.
interface exe_stage_if;
  logic        in_valid;
  logic        es_allowin;
  logic [31:0] pc_in;
  logic [11:0] alu_op_in;
  logic [31:0] alu_src1_in;
  logic [31:0] alu_src2_in;
  logic [2:0]  div_op_in;
  logic [31:0] rkd_value_in;
  logic [3:0]  data_sram_we_in;
  logic        mem_en_in;
  logic        rf_we_in;
  logic [4:0]  rf_waddr_in;
  logic        rf_or_mem_in;

  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic [31:0] es_result;
  logic [31:0] es_rkd_value;
  logic [3:0]  es_data_sram_we;
  logic        es_mem_en;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic        es_rf_or_mem;

  // Surrounding pipeline (ID upstream, MEM downstream)
  modport master (
    output in_valid, pc_in, alu_op_in, alu_src1_in, alu_src2_in, div_op_in,
           rkd_value_in, data_sram_we_in, mem_en_in, rf_we_in, rf_waddr_in,
           rf_or_mem_in, ms_allowin,
    input  es_allowin, es_to_ms_valid, es_pc, es_result, es_rkd_value,
           es_data_sram_we, es_mem_en, es_rf_we, es_rf_waddr, es_rf_or_mem
  );

  // Execute stage itself
  modport slave (
    input  in_valid, pc_in, alu_op_in, alu_src1_in, alu_src2_in, div_op_in,
           rkd_value_in, data_sram_we_in, mem_en_in, rf_we_in, rf_waddr_in,
           rf_or_mem_in, ms_allowin,
    output es_allowin, es_to_ms_valid, es_pc, es_result, es_rkd_value,
           es_data_sram_we, es_mem_en, es_rf_we, es_rf_waddr, es_rf_or_mem
  );
endinterface

// File: rtl/exe_stage.sv
// LoongArch execute stage: one-hot ALU, 32-step restoring divider, valid/allowin
// hand-off to MEM and forwarding info back to ID.
module exe_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  exe_stage_if.slave  bus,
  output logic        es_fwd_we_o,
  output logic [4:0]  es_fwd_waddr_o,
  output logic [31:0] es_fwd_data_o,
  output logic        es_fwd_ready_o,
  output logic        div_busy_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} divState_e;

  logic        esValid_q;
  logic [31:0] pc_q;
  logic [11:0] aluOp_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [2:0]  divOp_q;
  logic [31:0] rkd_q;
  logic [3:0]  sramWe_q;
  logic        memEn_q;
  logic        rfWe_q;
  logic [4:0]  rfWaddr_q;
  logic        rfOrMem_q;

  divState_e        divState_q, divState_d;
  logic [CNT_W-1:0] divCnt_q, divCnt_d;
  logic [31:0]      quot_q, quot_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      divisor_q, divisor_d;
  logic             negQ_q, negQ_d;
  logic             negR_q, negR_d;

  logic        readyGo;
  logic        accept;
  logic        leave;
  logic [31:0] aluResult;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [32:0] remShift;
  logic [33:0] diff;
  logic [31:0] absA;
  logic [31:0] absB;

  assign readyGo            = !divOp_q[2] || (divState_q == DIV_DONE);
  assign bus.es_allowin     = !esValid_q || (readyGo && bus.ms_allowin);
  assign accept             = bus.in_valid && bus.es_allowin && !flush_i;
  assign bus.es_to_ms_valid = esValid_q && readyGo && !flush_i;
  assign leave              = bus.es_to_ms_valid && bus.ms_allowin;

  // Fields only load on accept, so they naturally hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      esValid_q <= 1'b0;
      pc_q      <= '0;
      aluOp_q   <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      divOp_q   <= '0;
      rkd_q     <= '0;
      sramWe_q  <= '0;
      memEn_q   <= 1'b0;
      rfWe_q    <= 1'b0;
      rfWaddr_q <= '0;
      rfOrMem_q <= 1'b0;
    end else begin
      if (flush_i)    esValid_q <= 1'b0;
      else if (accept) esValid_q <= 1'b1;
      else if (leave)  esValid_q <= 1'b0;
      if (accept) begin
        pc_q      <= bus.pc_in;
        aluOp_q   <= bus.alu_op_in;
        src1_q    <= bus.alu_src1_in;
        src2_q    <= bus.alu_src2_in;
        divOp_q   <= bus.div_op_in;
        rkd_q     <= bus.rkd_value_in;
        sramWe_q  <= bus.data_sram_we_in;
        memEn_q   <= bus.mem_en_in;
        rfWe_q    <= bus.rf_we_in;
        rfWaddr_q <= bus.rf_waddr_in;
        rfOrMem_q <= bus.rf_or_mem_in;
      end
    end
  end

  always_comb begin
    aluResult = '0;
    case (aluOp_q)
      12'h001: aluResult = src1_q + src2_q;
      12'h002: aluResult = src1_q - src2_q;
      12'h004: aluResult = {31'd0, $signed(src1_q) < $signed(src2_q)};
      12'h008: aluResult = {31'd0, src1_q < src2_q};
      12'h010: aluResult = src1_q & src2_q;
      12'h020: aluResult = ~(src1_q | src2_q);
      12'h040: aluResult = src1_q | src2_q;
      12'h080: aluResult = src1_q ^ src2_q;
      12'h100: aluResult = src1_q << src2_q[4:0];
      12'h200: aluResult = src1_q >> src2_q[4:0];
      12'h400: aluResult = $signed(src1_q) >>> src2_q[4:0];
      12'h800: aluResult = src2_q;
      default: aluResult = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divState_q <= DIV_IDLE;
      divCnt_q   <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      negQ_q     <= 1'b0;
      negR_q     <= 1'b0;
    end else begin
      divState_q <= divState_d;
      divCnt_q   <= divCnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      negQ_q     <= negQ_d;
      negR_q     <= negR_d;
    end
  end

  // Restoring divider on magnitudes; quot_q doubles as the dividend shifter.
  always_comb begin
    divState_d = divState_q;
    divCnt_d   = divCnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    negQ_d     = negQ_q;
    negR_d     = negR_q;
    remShift   = {rem_q, quot_q[31]};
    diff       = {1'b0, remShift} - {2'b00, divisor_q};
    absA       = (divOp_q[1] && src1_q[31]) ? -src1_q : src1_q;
    absB       = (divOp_q[1] && src2_q[31]) ? -src2_q : src2_q;
    if (flush_i) begin
      divState_d = DIV_IDLE;
      divCnt_d   = '0;
    end else begin
      case (divState_q)
        DIV_IDLE: begin
          if (esValid_q && divOp_q[2]) begin
            divCnt_d = '0;
            if (src2_q == 32'd0) begin
              quot_d     = '1;
              rem_d      = src1_q;
              negQ_d     = 1'b0;
              negR_d     = 1'b0;
              divState_d = DIV_DONE;
            end else begin
              quot_d     = absA;
              rem_d      = '0;
              divisor_d  = absB;
              negQ_d     = divOp_q[1] && (src1_q[31] ^ src2_q[31]);
              negR_d     = divOp_q[1] && src1_q[31];
              divState_d = DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          quot_d   = {quot_q[30:0], !diff[33]};
          rem_d    = diff[33] ? remShift[31:0] : diff[31:0];
          divCnt_d = divCnt_q + 1'b1;
          if (divCnt_q == CNT_W'(DIV_CYCLES - 1)) divState_d = DIV_DONE;
        end
        DIV_DONE: begin
          if (leave) divState_d = DIV_IDLE;
        end
        default: divState_d = DIV_IDLE;
      endcase
    end
  end

  assign quotient  = negQ_q ? -quot_q : quot_q;
  assign remainder = negR_q ? -rem_q : rem_q;

  assign bus.es_pc           = pc_q;
  assign bus.es_result       = divOp_q[2] ? (divOp_q[0] ? remainder : quotient) : aluResult;
  assign bus.es_rkd_value    = rkd_q;
  assign bus.es_data_sram_we = sramWe_q;
  assign bus.es_mem_en       = memEn_q;
  assign bus.es_rf_we        = rfWe_q;
  assign bus.es_rf_waddr     = rfWaddr_q;
  assign bus.es_rf_or_mem    = rfOrMem_q;

  // Ready is qualified by valid so an empty stage never advertises usable data.
  assign es_fwd_we_o    = esValid_q && rfWe_q && (rfWaddr_q != 5'd0);
  assign es_fwd_waddr_o = rfWaddr_q;
  assign es_fwd_data_o  = bus.es_result;
  assign es_fwd_ready_o = esValid_q && !rfOrMem_q && readyGo;
  assign div_busy_o     = (divState_q == DIV_BUSY);

endmodule

// File: tb/tb_exe_stage.sv
// Directed scoreboard bench for exe_stage: ALU ops, divider latency and corner
// cases, MEM back-pressure, flush and asynchronous reset.
module tb_exe_stage;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        fwdWe;
  logic [4:0]  fwdWaddr;
  logic [31:0] fwdData;
  logic        fwdReady;
  logic        divBusy;

  exe_stage_if bus();

  exe_stage #(.DIV_CYCLES(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .bus            (bus.slave),
    .es_fwd_we_o    (fwdWe),
    .es_fwd_waddr_o (fwdWaddr),
    .es_fwd_data_o  (fwdData),
    .es_fwd_ready_o (fwdReady),
    .div_busy_o     (divBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] rkd;
  } sbEntry_t;

  sbEntry_t expQ[$];
  int checks   = 0;
  int failures = 0;

  logic [11:0] aluOps [14] = '{12'h001, 12'h002, 12'h004, 12'h008, 12'h010, 12'h020, 12'h040,
                               12'h080, 12'h100, 12'h200, 12'h400, 12'h800, 12'h003, 12'h000};
  logic [31:0] aluA   [14] = '{32'h7FFFFFFF, 32'h5, 32'h1, 32'h1, 32'hF0F0F0F0, 32'hF0F0F0F0,
                               32'h12340000, 32'hFFFF0000, 32'h3, 32'h80000010, 32'h80000010,
                               32'h55555555, 32'h7, 32'h9};
  logic [31:0] aluB   [14] = '{32'h1, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFF00FF00, 32'h0F0F0000,
                               32'h00005678, 32'h0F0F0F0F, 32'h24, 32'h4, 32'h4,
                               32'hABCDE000, 32'h8, 32'h9};
  logic [31:0] aluExp [14] = '{32'h80000000, 32'hFFFFFFFE, 32'h0, 32'h1, 32'hF000F000, 32'h00000F0F,
                               32'h12345678, 32'hF0F00F0F, 32'h30, 32'h08000001, 32'hF8000001,
                               32'hABCDE000, 32'h0, 32'h0};

  logic [2:0]  divOps [9] = '{3'b110, 3'b111, 3'b100, 3'b101, 3'b111, 3'b110, 3'b111, 3'b100, 3'b101};
  logic [31:0] divA   [9] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h1234, 32'h1234, 32'hFFFFFFF9,
                              32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] divB   [9] = '{32'h2, 32'h2, 32'h0, 32'h0, 32'h0,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'h10, 32'h10};
  logic [31:0] divExp [9] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'hFFFFFFF9,
                              32'h80000000, 32'h0, 32'h0FFFFFFF, 32'hF};
  int          divLat [9] = '{33, 33, 1, 1, 1, 33, 33, 33, 33};
  int          divBsy [9] = '{32, 32, 0, 0, 0, 32, 32, 32, 32};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [11:0] op, input logic [31:0] s1,
                               input logic [31:0] s2, input logic [2:0] dop);
    bus.in_valid        = 1'b1;
    bus.pc_in           = pc;
    bus.alu_op_in       = op;
    bus.alu_src1_in     = s1;
    bus.alu_src2_in     = s2;
    bus.div_op_in       = dop;
    bus.rkd_value_in    = s1 ^ 32'hA5A5A5A5;
    bus.data_sram_we_in = 4'h0;
    bus.mem_en_in       = 1'b0;
    bus.rf_we_in        = 1'b1;
    bus.rf_waddr_in     = 5'd3;
    bus.rf_or_mem_in    = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [11:0] op, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [2:0] dop, input logic [31:0] expRes);
    sbEntry_t e;
    int n = 0;
    while (!bus.es_allowin && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("issue_allowin", {31'd0, bus.es_allowin}, 32'd1);
    applyStimulus(pc, op, s1, s2, dop);
    e.pc = pc; e.result = expRes; e.rkd = s1 ^ 32'hA5A5A5A5;
    expQ.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Waits for a transfer to MEM, counting idle cycles, busy cycles and allowin leaks.
  task automatic drain(input string tag, input int budget, output int lat, output int busy);
    sbEntry_t e;
    bit seen = 1'b0;
    int leak = 0;
    lat  = 0;
    busy = 0;
    while (!seen && lat <= budget) begin
      @(negedge clk);
      if (bus.es_to_ms_valid && bus.ms_allowin) seen = 1'b1;
      else begin
        lat++;
        if (divBusy) busy++;
        if (bus.es_allowin) leak++;
      end
    end
    checkOutput({tag, "_seen"}, {31'd0, seen}, 32'd1);
    checkOutput({tag, "_allowin_leak"}, leak, 32'd0);
    if (seen) begin
      checkOutput({tag, "_sb_nonempty"}, {31'd0, expQ.size() > 0}, 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({tag, "_result"}, bus.es_result, e.result);
        checkOutput({tag, "_pc"}, bus.es_pc, e.pc);
        checkOutput({tag, "_rkd"}, bus.es_rkd_value, e.rkd);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    sbEntry_t dropped;
    int lat;
    int busy;

    bus.in_valid = 1'b0; bus.pc_in = '0; bus.alu_op_in = '0; bus.alu_src1_in = '0;
    bus.alu_src2_in = '0; bus.div_op_in = '0; bus.rkd_value_in = '0; bus.data_sram_we_in = '0;
    bus.mem_en_in = 1'b0; bus.rf_we_in = 1'b0; bus.rf_waddr_in = '0; bus.rf_or_mem_in = 1'b0;
    bus.ms_allowin = 1'b1;

    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_allowin", {31'd0, bus.es_allowin}, 32'd1);
    checkOutput("rst_to_ms_valid", {31'd0, bus.es_to_ms_valid}, 32'd0);
    checkOutput("rst_pc", bus.es_pc, 32'd0);
    checkOutput("rst_result", bus.es_result, 32'd0);
    checkOutput("rst_div_busy", {31'd0, divBusy}, 32'd0);
    checkOutput("rst_fwd_we", {31'd0, fwdWe}, 32'd0);
    checkOutput("rst_fwd_ready", {31'd0, fwdReady}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h40, 12'h001, 32'h7FFFFFFF, 32'h1, 3'b000, 32'h80000000);
    #2;
    checkOutput("fwd_we", {31'd0, fwdWe}, 32'd1);
    checkOutput("fwd_waddr", {27'd0, fwdWaddr}, 32'd3);
    checkOutput("fwd_data", fwdData, 32'h80000000);
    checkOutput("fwd_ready", {31'd0, fwdReady}, 32'd1);
    drain("add_first", 5, lat, busy);
    checkOutput("add_first_lat", lat, 32'd0);

    for (int i = 0; i < 14; i++) begin
      issue(32'h100 + i * 4, aluOps[i], aluA[i], aluB[i], 3'b000, aluExp[i]);
      drain($sformatf("alu%0d", i), 5, lat, busy);
      checkOutput($sformatf("alu%0d_lat", i), lat, 32'd0);
    end

    for (int i = 0; i < 9; i++) begin
      issue(32'h200 + i * 4, 12'h001, divA[i], divB[i], divOps[i], divExp[i]);
      drain($sformatf("div%0d", i), 40, lat, busy);
      checkOutput($sformatf("div%0d_lat", i), lat, divLat[i]);
      checkOutput($sformatf("div%0d_busy", i), busy, divBsy[i]);
    end

    // Back-to-back divides: second is accepted on the edge the first leaves.
    issue(32'h300, 12'h000, 32'd100, 32'hFFFFFFF9, 3'b110, 32'hFFFFFFF2);
    applyStimulus(32'h304, 12'h000, 32'd100, 32'd7, 3'b101);
    dropped.pc = 32'h304; dropped.result = 32'd2; dropped.rkd = 32'd100 ^ 32'hA5A5A5A5;
    expQ.push_back(dropped);
    drain("b2b_first", 40, lat, busy);
    bus.in_valid = 1'b0;
    checkOutput("b2b_first_lat", lat, 32'd33);
    drain("b2b_second", 40, lat, busy);
    checkOutput("b2b_second_lat", lat, 32'd33);

    bus.ms_allowin = 1'b0;
    issue(32'h2000, 12'h001, 32'd3, 32'd4, 3'b000, 32'd7);
    applyStimulus(32'h2004, 12'h002, 32'd20, 32'd3, 3'b000);
    dropped.pc = 32'h2004; dropped.result = 32'h11; dropped.rkd = 32'd20 ^ 32'hA5A5A5A5;
    expQ.push_back(dropped);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d_valid", k), {31'd0, bus.es_to_ms_valid}, 32'd1);
      checkOutput($sformatf("stall%0d_allowin", k), {31'd0, bus.es_allowin}, 32'd0);
      checkOutput($sformatf("stall%0d_result", k), bus.es_result, 32'd7);
      checkOutput($sformatf("stall%0d_pc", k), bus.es_pc, 32'h2000);
      @(posedge clk); #1;
    end
    bus.ms_allowin = 1'b1;
    #1;
    checkOutput("stall_release_allowin", {31'd0, bus.es_allowin}, 32'd1);
    drain("stall_release", 2, lat, busy);
    bus.in_valid = 1'b0;
    checkOutput("stall_release_lat", lat, 32'd0);
    drain("stall_next", 2, lat, busy);
    checkOutput("stall_next_lat", lat, 32'd0);

    // Flush mid-divide, with a competing accept in the same cycle.
    issue(32'h3000, 12'h000, 32'd100, 32'd3, 3'b110, 32'd33);
    repeat (10) begin @(posedge clk); #1; end
    checkOutput("flush_pre_busy", {31'd0, divBusy}, 32'd1);
    flush = 1'b1;
    applyStimulus(32'h3004, 12'h001, 32'd1, 32'd1, 3'b000);
    @(negedge clk);
    checkOutput("flush_to_ms_valid", {31'd0, bus.es_to_ms_valid}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    dropped = expQ.pop_front();
    @(negedge clk);
    checkOutput("post_flush_to_ms_valid", {31'd0, bus.es_to_ms_valid}, 32'd0);
    checkOutput("post_flush_div_busy", {31'd0, divBusy}, 32'd0);
    checkOutput("post_flush_fwd_we", {31'd0, fwdWe}, 32'd0);
    checkOutput("post_flush_allowin", {31'd0, bus.es_allowin}, 32'd1);
    @(posedge clk); #1;

    issue(32'h4000, 12'h000, 32'hFFFFFFF9, 32'd2, 3'b110, 32'hFFFFFFFD);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_to_ms_valid", {31'd0, bus.es_to_ms_valid}, 32'd0);
    checkOutput("async_rst_div_busy", {31'd0, divBusy}, 32'd0);
    checkOutput("async_rst_pc", bus.es_pc, 32'd0);
    checkOutput("async_rst_result", bus.es_result, 32'd0);
    checkOutput("async_rst_fwd_we", {31'd0, fwdWe}, 32'd0);
    checkOutput("async_rst_fwd_data", fwdData, 32'd0);
    checkOutput("async_rst_allowin", {31'd0, bus.es_allowin}, 32'd1);
    dropped = expQ.pop_front();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h5000, 12'h001, 32'd2, 32'd2, 3'b000, 32'd4);
    drain("post_rst_add", 5, lat, busy);
    checkOutput("post_rst_add_lat", lat, 32'd0);

    checkOutput("sb_empty", expQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
